ysyx_22040237_reg_file_mp: RTL and testbench
============================================

Name: ysyx_22040237_reg_file_mp

Overview:
Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard, used by the pipelined core in place of the single-cycle register file. It provides NRD combinational read ports and NWR synchronous write ports. It also tracks which architectural registers have an in-flight producer, so decode can stall on RAW hazards. Register 0 is hardwired to zero.

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2)
AW, 5, address width; equals log2(NREGS)
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return registered state only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  write addresses; port i at [i*AW +: AW]
wr_data  in  NWR*XLEN  write data; port i at [i*XLEN +: XLEN]
wr_clr  in  NWR  per-port: this write also retires the producer (clears busy)
rd_en  in  NRD  per-port read enable
rd_addr  in  NRD*AW  read addresses
rd_data  out  NRD*XLEN  read data
rd_busy  out  NRD  addressed register has an outstanding producer
iss_en  in  1  issue: mark iss_addr busy
iss_addr  in  AW  destination register of the issued instruction
busy_vec  out  NREGS  scoreboard state, bit r = register r busy

Behaviour:
- Reset: on a rising edge with rst=1, all registers become 0 and busy_vec becomes 0. This overrides all writes and issues in that cycle. Reset mid-operation discards in-flight state; no partial updates.
- After reset: rd_data = 0 and rd_busy = 0 for every port until the first write or issue.
- Register 0: writes ignored, never busy (iss_addr=0 ignored, busy_vec[0] always 0), reads always return 0, and BYPASS never forwards to address 0.
- Effective write on port i: wr_en[i] && wr_addr_i != 0. Register updated at the next edge; write latency 1 cycle.
- Multiple ports writing the same address in one cycle: the highest-index port wins, for both the stored value and the bypass source.
- Read port j, combinational, zero latency:
  - rd_en[j]=0 gives rd_data=0 and rd_busy=0.
  - Otherwise, if BYPASS=1 and any effective write this cycle matches rd_addr_j, return that write's data (highest-index match).
  - Else return the stored register.
  - With BYPASS=0, return the stored register only; the written value appears the cycle after the write.
- Scoreboard, next state for register r != 0:
  - Set if iss_en && iss_addr==r.
  - Else cleared if any port i has an effective write with wr_clr[i]=1 to r.
  - Else hold.
  - Set wins over clear in the same cycle: the new producer supersedes the retiring one.
  - A write with wr_clr=0 never changes busy.
- rd_busy[j] = rd_en[j] && busy_vec[rd_addr_j] && !(BYPASS && a same-cycle effective wr_clr write targets rd_addr_j).
  - This lets a consumer proceed the cycle its producer writes back.
  - A same-cycle issue to the same address does not raise rd_busy; it takes effect next cycle.
- Issuing to an already-busy register is legal; the register stays busy until the next clearing write.
- All index arithmetic is unsigned. Addresses >= NREGS cannot occur since NREGS = 2^AW.

Test Plan:
1. Reset, then read x5 on both ports -> rd_data=0, rd_busy=0, busy_vec=0.
2. Write port0 x3=0xDEAD_BEEF_0000_0001 while reading x3 (BYPASS=1):
   - Same cycle: rd_data=0xDEADBEEF00000001.
   - With BYPASS=0: old value (0) that cycle, new value next cycle.
3. Port0 and port1 both write x7 (0x11, 0x22) -> x7=0x22 afterwards; same-cycle bypass also returns 0x22.
4. Write x0=0xFFFF, iss_en with iss_addr=0 -> reads of x0 return 0; busy_vec[0]=0.
5. Scoreboard sequence:
   - iss x9 -> busy_vec[9]=1 next cycle; read x9 gives rd_busy=1.
   - Writeback x9 with wr_clr=1 -> rd_busy=0 in the same cycle (BYPASS=1), busy_vec[9]=0 next cycle.
   - Repeat with iss x9 and clearing write x9 in the same cycle -> busy_vec[9] stays 1.
6. Fill x1..x31 with busy and data, assert rst mid-sequence together with writes -> all registers 0 and busy_vec=0 next cycle; the writes are dropped.

Source files
------------

// File: rtl/ysyx_22040237_reg_file_mp.sv
// Multi-port integer register file with same-cycle write-to-read bypass
// and a per-register busy scoreboard for RAW hazard detection in decode.
// x0 is hardwired to zero and is never busy.
module ysyx_22040237_reg_file_mp #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_clr,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NWR-1:0]   wr_eff;
  logic [NREGS-1:0] reg_we;
  logic [XLEN-1:0]  reg_wd [NREGS];

  // A write port is effective only when enabled and not targeting x0.
  always_comb begin
    wr_eff = '0;
    for (int i = 0; i < NWR; i++)
      wr_eff[i] = wr_en[i] && (wr_addr[i*AW +: AW] != '0);
  end

  // Resolve per-register write enable/data; ascending loop lets the highest port win.
  always_comb begin
    reg_we = '0;
    for (int r = 0; r < NREGS; r++) begin
      reg_wd[r] = '0;
      for (int i = 0; i < NWR; i++) begin
        if (wr_eff[i] && (wr_addr[i*AW +: AW] == AW'(r))) begin
          reg_we[r] = 1'b1;
          reg_wd[r] = wr_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: retiring writes clear, then an issue sets (issue wins).
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NWR; i++)
      if (wr_eff[i] && wr_clr[i])
        busy_d[wr_addr[i*AW +: AW]] = 1'b0;
    if (iss_en && (iss_addr != '0))
      busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Register array update; reset wipes every register and drops same-cycle writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        if (reg_we[r])
          regs[r] <= reg_wd[r];
    end
  end

  // Scoreboard state update; reset clears all outstanding producers.
  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  // Combinational read ports with optional forwarding and busy masking on writeback.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;
    logic            clr_hit;
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      ra      = rd_addr[j*AW +: AW];
      rv      = regs[ra];
      clr_hit = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        if ((BYPASS != 0) && wr_eff[i] && (wr_addr[i*AW +: AW] == ra)) begin
          rv = wr_data[i*XLEN +: XLEN];
          if (wr_clr[i])
            clr_hit = 1'b1;
        end
      end
      if (rd_en[j]) begin
        rd_data[j*XLEN +: XLEN] = rv;
        rd_busy[j]              = busy_q[ra] && !clr_hit;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_reg_file_mp.sv
// Directed bench for ysyx_22040237_reg_file_mp: one bypassing and one
// non-bypassing instance share all inputs so both behaviours are compared.
module tb_ysyx_22040237_reg_file_mp;

  localparam int XLEN = 64, NREGS = 32, AW = 5, NRD = 2, NWR = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]      wr_clr;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic [NREGS-1:0]    busy_vec, busy_vec_nb;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ysyx_22040237_reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec));

  ysyx_22040237_reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_nb));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic c);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = a;
    wr_data[p*XLEN +: XLEN] = d;
    wr_clr[p]             = c;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en   = 2'b11;
    rd_addr = {a1, a0};
  endtask

  initial begin
    idle();
    rd_en = '0; rd_addr = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    set_rd(5'd5, 5'd5); settle();
    check("rst_rd0", rd_data[63:0], 64'h0);
    check("rst_rd1", rd_data[127:64], 64'h0);
    check("rst_busy", {62'h0, rd_busy}, 64'h0);
    check("rst_bvec", {32'h0, busy_vec}, 64'h0);

    // Bypass of a single write
    set_wr(0, 5'd3, 64'hDEAD_BEEF_0000_0001, 1'b0);
    set_rd(5'd3, 5'd3); settle();
    check("byp_same", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    check("nobyp_same", rd_data_nb[63:0], 64'h0);
    tick(); idle(); settle();
    check("byp_next", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    check("nobyp_next", rd_data_nb[63:0], 64'hDEAD_BEEF_0000_0001);

    // Two ports write the same register: port 1 wins
    set_wr(0, 5'd7, 64'h11, 1'b0);
    set_wr(1, 5'd7, 64'h22, 1'b0);
    set_rd(5'd7, 5'd7); settle();
    check("dual_byp0", rd_data[63:0], 64'h22);
    check("dual_byp1", rd_data[127:64], 64'h22);
    check("dual_nb_same", rd_data_nb[63:0], 64'h0);
    tick(); idle(); settle();
    check("dual_store", rd_data[63:0], 64'h22);
    check("dual_nb_store", rd_data_nb[127:64], 64'h22);

    // Read enable gating
    rd_en = 2'b01; settle();
    check("rden_off_rd1", rd_data[127:64], 64'h0);
    check("rden_on_rd0", rd_data[63:0], 64'h22);

    // x0 is hardwired
    set_wr(0, 5'd0, 64'hFFFF, 1'b0);
    iss_en = 1'b1; iss_addr = 5'd0;
    set_rd(5'd0, 5'd0); settle();
    check("x0_byp", rd_data[63:0], 64'h0);
    tick(); idle(); settle();
    check("x0_store", rd_data[63:0], 64'h0);
    check("x0_nb", rd_data_nb[127:64], 64'h0);
    check("x0_bvec", {32'h0, busy_vec}, 64'h0);

    // Scoreboard: issue, then retire with a clearing writeback
    iss_en = 1'b1; iss_addr = 5'd9;
    set_rd(5'd9, 5'd9); settle();
    check("iss_same_busy", {62'h0, rd_busy}, 64'h0);
    tick(); idle(); settle();
    check("iss_bvec", {32'h0, busy_vec}, 64'h200);
    check("iss_busy", {62'h0, rd_busy}, 64'h3);
    check("iss_busy_nb", {62'h0, rd_busy_nb}, 64'h3);
    set_wr(0, 5'd9, 64'h99, 1'b1); settle();
    check("wb_busy_mask", {62'h0, rd_busy}, 64'h0);
    check("wb_busy_nb", {62'h0, rd_busy_nb}, 64'h3);
    check("wb_data", rd_data[63:0], 64'h99);
    tick(); idle(); settle();
    check("wb_bvec", {32'h0, busy_vec}, 64'h0);

    // Issue and clearing write in the same cycle: issue wins
    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd9;
    set_wr(1, 5'd9, 64'hAA, 1'b1);
    tick(); idle(); settle();
    check("set_wins", {32'h0, busy_vec}, 64'h200);

    // Non-clearing write leaves busy set; clearing write on port 1 retires
    set_wr(0, 5'd9, 64'hBB, 1'b0); settle();
    check("noclr_busy", {62'h0, rd_busy}, 64'h3);
    tick(); idle(); settle();
    check("noclr_bvec", {32'h0, busy_vec}, 64'h200);
    check("noclr_data", rd_data[63:0], 64'hBB);
    set_wr(1, 5'd9, 64'hCC, 1'b1);
    tick(); idle(); settle();
    check("p1clr_bvec", {32'h0, busy_vec}, 64'h0);

    // Fill x1..x31, then reset together with a write and an issue
    for (int r = 1; r < NREGS; r++) begin
      idle();
      iss_en = 1'b1; iss_addr = AW'(r);
      set_wr(0, AW'(r), 64'(r) * 64'h101, 1'b0);
      tick();
    end
    idle();
    set_rd(5'd31, 5'd4); settle();
    check("fill_bvec", {32'h0, busy_vec}, 64'hFFFF_FFFE);
    check("fill_x31", rd_data[63:0], 64'h1F1F);
    check("fill_x4", rd_data[127:64], 64'h404);
    rst = 1'b1;
    set_wr(0, 5'd4, 64'h44, 1'b0);
    iss_en = 1'b1; iss_addr = 5'd4;
    tick(); rst = 1'b0; idle(); settle();
    check("rst_mid_bvec", {32'h0, busy_vec}, 64'h0);
    check("rst_mid_x31", rd_data[63:0], 64'h0);
    check("rst_mid_x4", rd_data[127:64], 64'h0);
    check("rst_mid_busy", {62'h0, rd_busy}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
